// File: rtl/view_cell_fetch_pkg.sv
// Shared board geometry, timing bundle and address helper for the cell fetch stage.
package view_cell_fetch_pkg;

  localparam int WORD_SIZE      = 32;
  localparam int LOG_WORD_SIZE  = 5;
  localparam int LOG_BOARD_SIZE = 7;
  localparam int BOARD_SIZE     = 1 << LOG_BOARD_SIZE;
  localparam int LOG_VIEW_SIZE  = 5;
  localparam int VIEW_SIZE      = 1 << LOG_VIEW_SIZE;
  localparam int LOG_MAX_ADDR   = 2 * LOG_BOARD_SIZE - LOG_WORD_SIZE;

  typedef logic [LOG_BOARD_SIZE-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        blank;
  } vga_timing_t;

  // Idle timing: syncs are active-low, so they rest high, and the pixel is blanked.
  localparam vga_timing_t VGA_TIMING_RST = '{hcount: '0, vcount: '0,
                                             hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

  // Word address of a board cell: each row spans BOARD_SIZE/WORD_SIZE words, so the
  // row multiply is a shift.
  function automatic logic [LOG_MAX_ADDR-1:0] cell_addr(input pos_t p);
    logic [LOG_MAX_ADDR-1:0] row;
    logic [LOG_MAX_ADDR-1:0] col;
    row = LOG_MAX_ADDR'(p.y) << (LOG_BOARD_SIZE - LOG_WORD_SIZE);
    col = LOG_MAX_ADDR'(p.x >> LOG_WORD_SIZE);
    return row + col;
  endfunction

endpackage

// File: rtl/view_cell_fetch_if.sv
// Board memory read port. There is no valid/ready: the master presents a new read
// address every cycle and the slave returns the word for it a fixed number of cycles
// later, so the address itself is the only qualifier.
interface view_cell_fetch_if;
  import view_cell_fetch_pkg::*;

  logic [LOG_MAX_ADDR-1:0] addr_r_out;
  logic [WORD_SIZE-1:0]    data_in;

  modport master (output addr_r_out, input data_in);
  modport slave  (input addr_r_out, output data_in);
endinterface

// File: rtl/view_cell_fetch_pipe_delay.sv
// Fixed-depth shift register with a programmable reset value.
module pipe_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift one stage per clock; reset loads every stage with the idle value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/view_cell_fetch.sv
// Pixel-rate board fetch: maps each XVGA pixel to a cell in the view window, reads
// its board word, and emits the alive bit aligned with the delayed timing signals.
module view_cell_fetch
  import view_cell_fetch_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int LOG_CELL_PIX = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  coord_t      view_x_in,
  input  coord_t      view_y_in,
  view_cell_fetch_if.master mem,
  output logic        alive_out,
  output logic        in_view_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        done_out
);

  localparam int          PIPE_LAT   = MEM_LATENCY + 2;
  localparam logic [10:0] VIEW_PIX_H = 11'(VIEW_SIZE << LOG_CELL_PIX);
  localparam logic [9:0]  VIEW_PIX_V = 10'(VIEW_SIZE << LOG_CELL_PIX);

  logic                    r_armed;
  logic                    r_busy;
  pos_t                    r_view;
  logic [LOG_MAX_ADDR-1:0] r_addr;
  logic                    r_alive;
  logic                    r_in_view;

  logic                     w_capture;
  pos_t                     w_view;
  pos_t                     w_cell;
  logic                     w_in_view;
  logic                     w_done_mark;
  logic [LOG_WORD_SIZE-1:0] w_bit_d;
  logic                     w_in_view_d;
  logic                     w_done_d;
  vga_timing_t              w_tim_in;
  vga_timing_t              w_tim_out;

  // A frame start consumes a pending arm, including one arriving on that same cycle.
  assign w_capture = (hcount_in == '0) && (vcount_in == '0) && (r_armed || start_in);

  // The capturing pixel already uses the new origin so the whole frame sees one view.
  assign w_view    = w_capture ? '{x: view_x_in, y: view_y_in} : r_view;

  // Coordinate sums truncate to LOG_BOARD_SIZE bits, wrapping around a toroidal board.
  assign w_cell.x  = w_view.x + LOG_BOARD_SIZE'(hcount_in >> LOG_CELL_PIX);
  assign w_cell.y  = w_view.y + LOG_BOARD_SIZE'(vcount_in >> LOG_CELL_PIX);

  assign w_in_view = (hcount_in < VIEW_PIX_H) && (vcount_in < VIEW_PIX_V) && !blank_in;

  assign w_done_mark = (r_busy || w_capture) &&
                       (hcount_in == VIEW_PIX_H - 11'd1) && (vcount_in == VIEW_PIX_V - 10'd1);

  assign w_tim_in = '{hcount: hcount_in, vcount: vcount_in,
                      hsync: hsync_in, vsync: vsync_in, blank: blank_in};

  // Arm/busy tracking and view latch; the view only changes at a captured frame start.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_armed <= 1'b0;
      r_busy  <= 1'b0;
      r_view  <= '0;
    end else if (w_capture) begin
      r_armed <= 1'b0;
      r_busy  <= 1'b1;
      r_view  <= w_view;
    end else begin
      if (start_in) r_armed <= 1'b1;
      if (w_done_d) r_busy  <= 1'b0;
    end
  end

  // Read address is refreshed every cycle, blank or not.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_addr <= '0;
    else        r_addr <= cell_addr(w_cell);
  end

  assign mem.addr_r_out = r_addr;

  // Bit index must meet the returned word, one cycle after the address plus memory latency.
  pipe_delay #(.WIDTH(LOG_WORD_SIZE), .DEPTH(MEM_LATENCY + 1), .RST_VAL('0)) u_bit_delay (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_d    (w_cell.x[LOG_WORD_SIZE-1:0]),
    .o_q    (w_bit_d)
  );

  pipe_delay #(.WIDTH(1), .DEPTH(PIPE_LAT - 1), .RST_VAL(1'b0)) u_view_delay (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_d    (w_in_view),
    .o_q    (w_in_view_d)
  );

  pipe_delay #(.WIDTH(1), .DEPTH(PIPE_LAT), .RST_VAL(1'b0)) u_done_delay (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_d    (w_done_mark),
    .o_q    (w_done_d)
  );

  pipe_delay #(.WIDTH($bits(vga_timing_t)), .DEPTH(PIPE_LAT), .RST_VAL(VGA_TIMING_RST))
    u_timing_delay (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_d    (w_tim_in),
    .o_q    (w_tim_out)
  );

  // Final stage: pick the cell bit out of the returned word, masked outside the view.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_alive   <= 1'b0;
      r_in_view <= 1'b0;
    end else begin
      r_alive   <= mem.data_in[w_bit_d] & w_in_view_d;
      r_in_view <= w_in_view_d;
    end
  end

  assign alive_out   = r_alive;
  assign in_view_out = r_in_view;
  assign hcount_out  = w_tim_out.hcount;
  assign vcount_out  = w_tim_out.vcount;
  assign hsync_out   = w_tim_out.hsync;
  assign vsync_out   = w_tim_out.vsync;
  assign blank_out   = w_tim_out.blank;
  assign done_out    = w_done_d;

endmodule

// File: tb/tb_view_cell_fetch.sv
// Directed bench for view_cell_fetch with a board memory model and an expected-output queue.
module tb_view_cell_fetch;
  import view_cell_fetch_pkg::*;

  localparam int W   = 27;
  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in;
  logic        start_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, blank_in;
  coord_t      view_x_in, view_y_in;
  logic        alive_out, in_view_out, hsync_out, vsync_out, blank_out, done_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;

  view_cell_fetch_if mem_if ();

  view_cell_fetch dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .start_in    (start_in),
    .hcount_in   (hcount_in),
    .vcount_in   (vcount_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .blank_in    (blank_in),
    .view_x_in   (view_x_in),
    .view_y_in   (view_y_in),
    .mem         (mem_if),
    .alive_out   (alive_out),
    .in_view_out (in_view_out),
    .hcount_out  (hcount_out),
    .vcount_out  (vcount_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .blank_out   (blank_out),
    .done_out    (done_out)
  );

  // ---------------- board memory model (2-cycle read) ----------------
  logic [WORD_SIZE-1:0]    mem [1 << LOG_MAX_ADDR];
  logic [LOG_MAX_ADDR-1:0] a1, a2;
  always @(posedge clk) begin
    a1 <= mem_if.addr_r_out;
    a2 <= a1;
  end
  assign mem_if.data_in = mem[a2];

  // ---------------- scoreboard ----------------
  logic [W-1:0]            exp_q[$];
  int                      due_q[$];
  logic [LOG_MAX_ADDR-1:0] addr_q[$];
  int                      addr_due_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  bit m_armed, m_busy;
  int m_vx, m_vy;

  function automatic logic [W-1:0] pack_out(input logic dn, input logic al, input logic iv,
                                            input logic [10:0] h, input logic [9:0] v,
                                            input logic hs, input logic vs, input logic bl);
    return {dn, al, iv, h, v, hs, vs, bl};
  endfunction

  task automatic check_due();
    logic [W-1:0]            e, o;
    logic [LOG_MAX_ADDR-1:0] ea;
    int                      d;
    while (due_q.size() > 0 && due_q[0] == cyc) begin
      e = exp_q.pop_front();
      d = due_q.pop_front();
      o = pack_out(done_out, alive_out, in_view_out, hcount_out, vcount_out,
                   hsync_out, vsync_out, blank_out);
      n_checks++;
      assert (o === e) n_pass++;
      else $error("FAIL out cyc=%0d got %h exp %h (done,alive,inview,h,v,hs,vs,bl)", cyc, o, e);
    end
    while (addr_due_q.size() > 0 && addr_due_q[0] == cyc) begin
      ea = addr_q.pop_front();
      d  = addr_due_q.pop_front();
      n_checks++;
      assert (mem_if.addr_r_out === ea) n_pass++;
      else $error("FAIL addr cyc=%0d got %0d exp %0d", cyc, mem_if.addr_r_out, ea);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int h, input int v, input logic bl, input logic st,
                      input int vx, input int vy);
    bit cap, inv, al, dn, hs, vs;
    int ex, ey, bx, by, addr, bitn;
    @(negedge clk);
    check_due();
    hs = !(h >= 1048 && h < 1184);
    vs = !(v >= 771 && v < 777);
    rst_in    = 1'b0;
    start_in  = st;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    blank_in  = bl;
    view_x_in = coord_t'(vx);
    view_y_in = coord_t'(vy);

    cap  = (h == 0) && (v == 0) && (m_armed || st);
    ex   = cap ? vx : m_vx;
    ey   = cap ? vy : m_vy;
    bx   = (ex + h / 16) % BOARD_SIZE;
    by   = (ey + v / 16) % BOARD_SIZE;
    addr = by * (BOARD_SIZE / WORD_SIZE) + bx / WORD_SIZE;
    bitn = bx % WORD_SIZE;
    inv  = (h < 512) && (v < 512) && !bl;
    al   = mem[addr][bitn] && inv;
    dn   = (m_busy || cap) && h == 511 && v == 511;

    exp_q.push_back(pack_out(dn, al, inv, 11'(h), 10'(v), hs, vs, bl));
    due_q.push_back(cyc + LAT);
    addr_q.push_back(LOG_MAX_ADDR'(addr));
    addr_due_q.push_back(cyc + 1);

    if (cap) begin
      m_vx = vx; m_vy = vy; m_armed = 0; m_busy = 1;
    end else if (st) begin
      m_armed = 1;
    end
    if (dn) m_busy = 0;
    cyc++;
  endtask

  task automatic reset_step(input int h, input int v);
    @(negedge clk);
    check_due();
    rst_in    = 1'b1;
    start_in  = 1'b0;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    exp_q.delete(); due_q.delete(); addr_q.delete(); addr_due_q.delete();
    m_armed = 0; m_busy = 0; m_vx = 0; m_vy = 0;
    for (int i = 1; i <= LAT; i++) begin
      exp_q.push_back(pack_out(1'b0, 1'b0, 1'b0, 11'd0, 10'd0, 1'b1, 1'b1, 1'b1));
      due_q.push_back(cyc + i);
    end
    addr_q.push_back('0);
    addr_due_q.push_back(cyc + 1);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1300, 600, 1'b1, 1'b0, 0, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int h, v;
    rst_in = 1'b1; start_in = 1'b0; hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1; view_x_in = '0; view_y_in = '0;
    for (int i = 0; i < (1 << LOG_MAX_ADDR); i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0005;
    mem[2] = 32'hFFFF_FFFF;
    mem[3] = 32'h8000_0000;
    mem[4] = 32'hFFFF_FFFF;

    reset_step(0, 0);
    reset_step(0, 0);

    // Armed frame, view (0,0): first line free-runs from the frame start.
    step(0, 0, 1'b0, 1'b1, 0, 0);
    for (int i = 1; i < 64; i++) step(i, 0, 1'b0, 1'b0, 0, 0);
    // Out of view and blanked pixels over all-ones words.
    step(1100, 0, 1'b0, 1'b0, 0, 0);
    step(1100, 0, 1'b1, 1'b0, 0, 0);
    step(32, 16, 1'b1, 1'b0, 0, 0);
    step(32, 16, 1'b0, 1'b0, 0, 0);
    // Scattered pixels; view inputs wander but must be ignored mid-frame.
    for (int i = 0; i < 30; i++) begin
      h = $urandom_range(0, 1343);
      v = $urandom_range(1, 805);
      if (h == 511 && v == 511) h = 510;
      step(h, v, 1'(($urandom_range(0, 3) == 0)), 1'b0,
           $urandom_range(0, BOARD_SIZE - 1), $urandom_range(0, BOARD_SIZE - 1));
    end
    step(511, 511, 1'b0, 1'b0, 0, 0);
    idle(8);

    // Unarmed frame: start mid-frame, view inputs change twice, old view stays.
    step(0, 0, 1'b0, 1'b0, 50, 50);
    step(16, 0, 1'b0, 1'b0, 50, 50);
    step(200, 100, 1'b0, 1'b1, 10, 0);
    step(16, 0, 1'b0, 1'b0, 10, 0);
    step(300, 200, 1'b0, 1'b0, BOARD_SIZE - 1, 0);
    step(511, 511, 1'b0, 1'b0, BOARD_SIZE - 1, 0);
    idle(8);

    // Armed frame latching view_x = BOARD_SIZE-1: column wrap.
    step(0, 0, 1'b0, 1'b0, BOARD_SIZE - 1, 0);
    step(16, 0, 1'b0, 1'b0, 3, 3);
    step(32, 0, 1'b0, 1'b0, 3, 3);
    idle(4);
    step(511, 511, 1'b0, 1'b0, 0, 0);
    idle(8);
    step(511, 511, 1'b0, 1'b0, 0, 0);
    idle(6);

    // Armed frame interrupted by reset at hcount=500.
    step(0, 0, 1'b0, 1'b1, 5, 3);
    for (int i = 490; i < 500; i++) step(i, 511, 1'b0, 1'b0, 5, 3);
    reset_step(500, 511);
    for (int i = 501; i < 512; i++) step(i, 511, 1'b0, 1'b0, 5, 3);
    idle(6);

    // First armed frame after reset recaptures the view.
    step(0, 0, 1'b0, 1'b1, 20, 7);
    step(16, 16, 1'b0, 1'b0, 0, 0);
    idle(6);

    // Drain remaining expectations without new stimulus.
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      check_due();
      cyc++;
    end
    n_checks++;
    assert (exp_q.size() == 0 && addr_q.size() == 0) n_pass++;
    else $error("FAIL drain got %0d/%0d left exp 0/0", exp_q.size(), addr_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/view_cell_fetch.md
Name: view_cell_fetch

Overview:
- Pixel-rate fetch stage between the board memory and the pixel compositor; fills the slot left open in the renderer.
- Takes raw XVGA timing (hcount/vcount/sync/blank) and converts each pixel to a board cell inside the current view window.
- Issues one registered read per pixel to the board memory and extracts that cell's alive bit from the returned word.
- Emits the alive bit together with the timing signals, all delayed by the same fixed pipeline latency, so the downstream compositor and cursor_render stay aligned.

Parameters:
- MEM_LATENCY, 2, cycles from addr_r_out change to matching data_in (board BRAM read latency).
- LOG_CELL_PIX, 4, log2 of cell edge in pixels (16x16-pixel cells).
- PIPE_LAT, MEM_LATENCY+2, derived total latency from pixel inputs to outputs; not overridable.

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  synchronous active-high reset
- start_in  in  1  pulse: arm view capture at the next frame start
- hcount_in  in  11  XVGA pixel column
- vcount_in  in  10  XVGA line
- hsync_in  in  1  active-low hsync
- vsync_in  in  1  active-low vsync
- blank_in  in  1  blanking
- view_x_in  in  LOG_BOARD_SIZE  view origin column, board coordinates
- view_y_in  in  LOG_BOARD_SIZE  view origin row, board coordinates
- data_in  in  WORD_SIZE  board memory read data
- addr_r_out  out  LOG_MAX_ADDR  board memory read address
- alive_out  out  1  cell under the delayed pixel is alive
- in_view_out  out  1  delayed pixel lies inside the view window
- hcount_out  out  11  hcount_in delayed PIPE_LAT
- vcount_out  out  10  vcount_in delayed PIPE_LAT
- hsync_out  out  1  hsync_in delayed PIPE_LAT
- vsync_out  out  1  vsync_in delayed PIPE_LAT
- blank_out  out  1  blank_in delayed PIPE_LAT
- done_out  out  1  one-cycle pulse: last visible pixel of an armed frame has left the pipeline

Behaviour:
- Reset values:
  - addr_r_out, alive_out, in_view_out, hcount_out, vcount_out, done_out = 0.
  - hsync_out = vsync_out = 1; blank_out = 1.
  - All delay stages cleared to these same values. Armed and busy flags cleared. Latched view = 0.
- Frame start is the cycle with hcount_in==0 && vcount_in==0.
- View capture and arming:
  - start_in sets armed.
  - At frame start, if armed (or start_in is high that same cycle), latch view_x_in/view_y_in, clear armed, set busy.
  - Otherwise the previous latched view is kept; no mid-frame view change ever occurs.
- Cycle t (pixel inputs sampled):
  - cx = hcount_in >> LOG_CELL_PIX; cy = vcount_in >> LOG_CELL_PIX.
  - in_view = (hcount_in < VIEW_SIZE<<LOG_CELL_PIX) && (vcount_in < VIEW_SIZE<<LOG_CELL_PIX) && !blank_in.
  - bx = (view_x + cx) mod BOARD_SIZE; by = (view_y + cy) mod BOARD_SIZE. Wrap is done by truncation to LOG_BOARD_SIZE bits, giving a toroidal board.
- Cycle t+1: addr_r_out <= by*(BOARD_SIZE/WORD_SIZE) + (bx >> LOG_WORD_SIZE).
  - The address updates every cycle, including blank cycles; the memory is read-only here, so there is no enable.
- Cycle t+1+MEM_LATENCY: data_in corresponds to that address.
  - The bit index (bx mod WORD_SIZE) travels through its own delay line.
  - Bit i of a word is the cell at column word_idx*WORD_SIZE + i.
- Cycle t+2+MEM_LATENCY (= t+PIPE_LAT): alive_out <= data_in[bit] & in_view_delayed.
  - Timing outputs and in_view_out emerge on the same cycle.
- done_out:
  - Pulses when the pixel (VIEW_SIZE<<LOG_CELL_PIX)-1, (VIEW_SIZE<<LOG_CELL_PIX)-1 of a busy frame appears on the outputs; busy clears on that cycle.
  - A non-armed frame never pulses done_out.
- start_in while busy re-arms for the following frame and does not disturb the current one.
- Reset mid-frame: all state clears on the next edge. The first armed frame start after reset recaptures the view.
- Widths: all coordinate sums are computed at LOG_BOARD_SIZE bits. Address arithmetic uses LOG_MAX_ADDR bits, and the multiply is a shift.

Decomposition:
- Shared package, already present: WORD_SIZE, LOG_WORD_SIZE, BOARD_SIZE, LOG_BOARD_SIZE, VIEW_SIZE, LOG_VIEW_SIZE, LOG_MAX_ADDR, pos_t.
- Add to the package: a vga_timing_t struct (hcount, vcount, hsync, vsync, blank) for passing timing between stages.
- One sub-module: pipe_delay, a parameterised width/depth shift register with a reset value. It is instantiated for timing, bit index, in_view and the done marker.

Test Plan:
- Reset then free-run from hcount=0,vcount=0 -> outputs hold reset values for PIPE_LAT cycles; then hcount_out=0, vcount_out=0 exactly 4 cycles after input.
- view=(0,0), word at addr 0 = 0x...05 (WORD_SIZE=32), pixel (16,0) -> addr_r_out=0 at t+1; alive_out=0 for (16,0), alive_out=1 for (32,0), at t+4.
- view_x=BOARD_SIZE-1, pixel (16,0) -> bx wraps to 0, addr_r_out=0; pixel (0,0) -> addr = (BOARD_SIZE-1)>>LOG_WORD_SIZE.
- Blanked pixel or hcount=1100 with a memory word of all ones -> alive_out=0, in_view_out=0.
- start_in mid-frame with view_x_in changed, then change view_x_in again before the frame ends -> the current frame keeps the old view; the next frame latches the value present at frame start; done_out pulses once, at the last visible pixel of that frame + 4 cycles.
- rst_in asserted at hcount=500 -> next cycle all outputs at reset values and done_out never fires for that frame.
